// File: rtl/ft245_sync_tx.sv
// FT2232H 245 synchronous-FIFO transmit engine: drains FIFO B through a skid
// buffer onto WR#/data, throttled by TXE#, and flushes with SIWU# after bursts.
module ft245_sync_tx #(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 4,
    parameter int SIWU_IDLE = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_grant,
    input  logic              efb_n,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              txe_n,
    output logic              wr_n,
    output logic [DATA_W-1:0] ft_data,
    output logic              siwu_n,
    output logic [CNT_W-1:0]  tx_count,
    output logic              busy
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int IDL_W = (SIWU_IDLE > 1) ? $clog2(SIWU_IDLE) : 1;
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(BUF_DEPTH);
    localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'(SIWU_IDLE - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, FLUSH} state_t;

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_inc;
    logic [OCC_W-1:0]  occ, occ_ap, occ_nx;
    logic              inflight;
    logic [IDL_W-1:0]  idle_cnt;
    state_t            state, state_nx;
    logic              accept, push, wr_go;

    assign accept     = ~wr_n & ~txe_n;
    assign push       = inflight;
    assign occ_ap     = occ - OCC_W'(accept);
    assign occ_nx     = occ_ap + OCC_W'(push);
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);
    assign wr_go      = tx_grant & ~txe_n & (occ_nx != '0);

    // Combinational so the FIFO's empty flag, updated after its pop edge, is
    // honoured on the very next cycle; room counts the read still in flight.
    assign fifo_rd = rst_n & tx_grant & efb_n & (state != FLUSH) & (occ_nx < DEPTH_C);

    assign busy = (occ != '0) | inflight | (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (wr_go || !wr_n) state_nx = STREAM;
            STREAM:  if (occ_nx == '0 && !fifo_rd) state_nx = WAIT;
            WAIT: begin
                if (push)                      state_nx = STREAM;
                else if (idle_cnt == IDL_LAST) state_nx = FLUSH;
            end
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fifo_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            wr_n     <= 1'b1;
            ft_data  <= '0;
            siwu_n   <= 1'b1;
            tx_count <= '0;
            idle_cnt <= '0;
            state    <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (accept) begin
                rd_ptr   <= rd_ptr_inc;
                tx_count <= tx_count + CNT_W'(1);
            end
            occ      <= occ_nx;
            inflight <= fifo_rd;
            wr_n     <= ~wr_go;
            // Head changes only on a push into an empty slot or a pop that leaves data.
            if (push && occ_ap == '0)
                ft_data <= fifo_dout;
            else if (accept && occ_ap != '0)
                ft_data <= mem[rd_ptr_inc];
            state    <= state_nx;
            siwu_n   <= (state_nx != FLUSH);
            if (state == WAIT && state_nx == WAIT)
                idle_cnt <= idle_cnt + IDL_W'(1);
            else
                idle_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_ft245_sync_tx.sv
// Directed bench for ft245_sync_tx: FIFO B and FT2232H host models, burst,
// TXE# stall, grant drop, underflow gaps, reset and counter wrap.
module tb_ft245_sync_tx;

    localparam int DEPTH  = 4;
    localparam int IDLE_N = 16;

    logic clk = 1'b0, rst_n = 1'b0, tx_grant = 1'b0, efb_mask = 1'b0, txe_n = 1'b1;
    logic efb_n;
    logic [7:0] fifo_dout = '0;
    logic fifo_rd, wr_n, siwu_n, busy;
    logic [7:0] ft_data;
    logic [15:0] tx_count;
    logic rd4, wr4, siwu4, busy4;
    logic [7:0] ft4;
    logic [3:0] cnt4;

    logic [7:0] src [0:31];
    int fifo_len = 0;
    int rd_idx = 0;
    assign efb_n = efb_mask && (rd_idx < fifo_len);

    always #5 clk = ~clk;

    ft245_sync_tx #(.DATA_W(8), .BUF_DEPTH(DEPTH), .SIWU_IDLE(IDLE_N), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .tx_grant(tx_grant), .efb_n(efb_n), .fifo_rd(fifo_rd),
        .fifo_dout(fifo_dout), .txe_n(txe_n), .wr_n(wr_n), .ft_data(ft_data),
        .siwu_n(siwu_n), .tx_count(tx_count), .busy(busy));

    ft245_sync_tx #(.DATA_W(8), .BUF_DEPTH(DEPTH), .SIWU_IDLE(IDLE_N), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .tx_grant(tx_grant), .efb_n(efb_n), .fifo_rd(rd4),
        .fifo_dout(fifo_dout), .txe_n(txe_n), .wr_n(wr4), .ft_data(ft4),
        .siwu_n(siwu4), .tx_count(cnt4), .busy(busy4));

    int cyc = 0, rd_count = 0, acc_count = 0, rd_when_empty = 0, lockstep_err = 0;
    int first_acc_cyc = -1, last_acc_cyc = -1, siwu_lows = 0, siwu_cyc = -1;
    int first_rd_cyc = -1, first_wrl_cyc = -1, max_out = 0;
    logic [7:0] rx [$];
    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO B and host models, sampled on the active edge before DUT updates land
    always @(posedge clk) begin
        cyc = cyc + 1;
        if ({rd4, wr4, siwu4, busy4, ft4} !== {fifo_rd, wr_n, siwu_n, busy, ft_data})
            lockstep_err++;
        if (!rst_n) begin
            rd_idx <= 0;
            rd_count = 0;
            acc_count = 0;
            rx.delete();
            first_acc_cyc = -1;
            last_acc_cyc = -1;
        end else begin
            if (fifo_rd) begin
                if (!efb_n) rd_when_empty++;
                if (rd_idx < 32) fifo_dout <= src[rd_idx];
                rd_idx <= rd_idx + 1;
                rd_count++;
            end
            if (!wr_n && !txe_n) begin
                rx.push_back(ft_data);
                acc_count++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            siwu_lows = 0;
            siwu_cyc = -1;
            first_rd_cyc = -1;
            first_wrl_cyc = -1;
        end else begin
            if (!siwu_n) begin
                siwu_lows++;
                siwu_cyc = cyc;
            end
            if (fifo_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (!wr_n && first_wrl_cyc < 0) first_wrl_cyc = cyc;
            if (rd_count - acc_count > max_out) max_out = rd_count - acc_count;
        end
    end

    task automatic start(input int n, input int base, input logic g, input logic t);
        @(negedge clk);
        rst_n = 1'b0;
        tx_grant = g;
        txe_n = t;
        efb_mask = 1'b1;
        fifo_len = n;
        for (int i = 0; i < n; i++) src[i] = 8'(base + i);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_acc(input int n, input int budget);
        for (int i = 0; i < budget && acc_count < n; i++) @(negedge clk);
    endtask

    task automatic wait_siwu(input int budget);
        for (int i = 0; i < budget && siwu_lows == 0; i++) @(negedge clk);
    endtask

    task automatic check_rx(input string tag, input int n, input int base);
        for (int i = 0; i < n; i++)
            check(tag, (i < rx.size()) ? rx[i] : 8'hxx, 8'(base + i));
    endtask

    initial begin
        // T1: asynchronous reset in the middle of a stream
        start(8, 8'hA0, 1'b1, 1'b0);
        for (int i = 0; i < 20 && wr_n !== 1'b0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("t1_pre_wr_n", wr_n, 0);
        check("t1_pre_count", tx_count, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t1_wr_n", wr_n, 1);
        check("t1_siwu_n", siwu_n, 1);
        check("t1_fifo_rd", fifo_rd, 0);
        check("t1_tx_count", tx_count, 0);
        check("t1_busy", busy, 0);
        check("t1_ft_data", ft_data, 0);

        // T2: 16-byte burst, latency, back-to-back, SIWU# timing
        start(16, 1, 1'b1, 1'b0);
        wait_acc(16, 60);
        check("t2_acc", acc_count, 16);
        check_rx("t2_byte", 16, 1);
        check("t2_latency", first_wrl_cyc - first_rd_cyc, 2);
        check("t2_b2b", last_acc_cyc - first_acc_cyc, 15);
        check("t2_tx_count", tx_count, 16);
        wait_siwu(40);
        repeat (3) @(negedge clk);
        check("t2_siwu_pulses", siwu_lows, 1);
        check("t2_siwu_delay", siwu_cyc - last_acc_cyc, IDLE_N);
        check("t2_busy_idle", busy, 0);

        // T3: TXE# stall while byte 0x05 is on the bus
        start(16, 1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && !(wr_n === 1'b0 && ft_data === 8'h05); i++) @(negedge clk);
        check("t3_reach", ft_data, 8'h05);
        txe_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold", ft_data, 8'h05);
            check("t3_wr_n_high", wr_n, 1);
        end
        check("t3_acc_frozen", acc_count, 4);
        txe_n = 1'b0;
        wait_acc(16, 60);
        check("t3_acc", acc_count, 16);
        check_rx("t3_byte", 16, 1);
        check("t3_reads", rd_count, 16);
        check("t3_tx_count", tx_count, 16);

        // T4: grant drop with 3 buffered + 1 in flight
        start(8, 1, 1'b1, 1'b1);
        for (int i = 0; i < 20 && rd_count < 4; i++) @(negedge clk);
        check("t4_rd_count", rd_count, 4);
        check("t4_rd_stop", fifo_rd, 0);
        tx_grant = 1'b0;
        txe_n = 1'b0;
        @(negedge clk);
        check("t4_wr_n", wr_n, 1);
        check("t4_fifo_rd", fifo_rd, 0);
        repeat (3) @(negedge clk);
        check("t4_no_reads", rd_count, 4);
        check("t4_no_acc", acc_count, 0);
        check("t4_busy", busy, 1);
        tx_grant = 1'b1;
        #1 check("t4_full_no_rd", fifo_rd, 0);
        wait_acc(8, 40);
        check("t4_acc", acc_count, 8);
        check_rx("t4_byte", 8, 1);

        // T5: FIFO empty flag toggling every 2 cycles
        start(12, 1, 1'b1, 1'b0);
        for (int i = 0; i < 150 && acc_count < 12; i++) begin
            @(negedge clk);
            efb_mask = ((i / 2) % 2) == 0;
        end
        efb_mask = 1'b1;
        check("t5_acc", acc_count, 12);
        check("t5_no_early_siwu", siwu_lows, 0);
        check_rx("t5_byte", 12, 1);
        wait_siwu(40);
        check("t5_siwu_pulses", siwu_lows, 1);
        check("t5_siwu_delay", siwu_cyc - last_acc_cyc, IDLE_N);
        check("t5_empty_reads", rd_when_empty, 0);

        // T6: counter wrap on a 4-bit build
        start(17, 1, 1'b1, 1'b0);
        for (int i = 0; i < 60 && tx_count < 14; i++) @(negedge clk);
        check("t6_cnt4_at14", cnt4, 14);
        wait_acc(17, 40);
        check("t6_wrap", cnt4, 1);
        check("t6_cnt16", tx_count, 17);

        check("empty_reads_total", rd_when_empty, 0);
        check("outstanding_le_depth", max_out <= DEPTH, 1);
        check("lockstep_cnt_w4", lockstep_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
